// File: rtl/stop_pkg.sv
// Shared symbol constants and FSM state encoding for the serial comma-alignment receiver.
package stop_pkg;

    localparam logic [7:0] COMMA_BC = 8'hBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/stop_shift_det.sv
// Serial shift register with a combinational comma match on the look-ahead word.
// Latency: comma_hit reflects the bit being sampled this cycle; no backpressure.
module stop_shift_det
    import stop_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = COMMA_BC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_serial,
    output logic [WIDTH-1:0] sr_next,
    output logic             comma_hit
);

    logic [WIDTH-1:0] sr;

    assign sr_next   = {sr[WIDTH-2:0], in_serial};
    assign comma_hit = (sr_next == COMMA);

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= sr_next;
        end
    end

endmodule

// File: rtl/stop_comma_align.sv
// Comma-hunting serial-to-parallel receiver; outputs update on the edge sampling a symbol's last bit.
// No backpressure: one bit accepted every clk, symbols held for WIDTH cycles.
module stop_comma_align
    import stop_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = COMMA_BC,
    parameter int               LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_serial,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             byte_strobe,
    output logic             active
);

    localparam int CW  = $clog2(WIDTH);
    localparam int CCW = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0]  BIT_MAX = CW'(WIDTH - 1);
    localparam logic [CCW-1:0] LOCK    = CCW'(LOCK_COUNT);

    state_t           state, state_d;
    logic [CW-1:0]    bit_cnt, bit_cnt_d;
    logic [CCW-1:0]   comma_cnt, comma_cnt_d;
    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_d, byte_strobe_d, active_d;
    logic [WIDTH-1:0] sr_next;
    logic             comma_hit;
    logic             boundary;

    stop_shift_det #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_shift_det (
        .clk       (clk),
        .reset     (reset),
        .in_serial (in_serial),
        .sr_next   (sr_next),
        .comma_hit (comma_hit)
    );

    assign boundary = (bit_cnt == BIT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            bit_cnt     <= '0;
            comma_cnt   <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            comma_cnt   <= comma_cnt_d;
            out_data    <= out_data_d;
            out_valid   <= out_valid_d;
            byte_strobe <= byte_strobe_d;
            active      <= active_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            HUNT: begin
                if (comma_hit) begin
                    state_d = (LOCK_COUNT == 1) ? ACTIVE : SYNC;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (!comma_hit) begin
                        state_d = HUNT;
                    end else if (comma_cnt + CCW'(1) >= LOCK) begin
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE:  state_d = ACTIVE;
            default: state_d = HUNT;
        endcase
    end

    // The lock-edge comma only raises active; data outputs change solely at ACTIVE boundaries.
    always_comb begin
        bit_cnt_d     = boundary ? '0 : bit_cnt + CW'(1);
        comma_cnt_d   = comma_cnt;
        out_data_d    = out_data;
        out_valid_d   = out_valid;
        byte_strobe_d = 1'b0;
        active_d      = (state_d == ACTIVE);
        case (state)
            HUNT: begin
                bit_cnt_d     = '0;
                byte_strobe_d = comma_hit;
                if (comma_hit) begin
                    comma_cnt_d = CCW'(1);
                end
            end
            SYNC: begin
                if (boundary) begin
                    byte_strobe_d = 1'b1;
                    if (!comma_hit) begin
                        comma_cnt_d = '0;
                    end else if (comma_cnt != LOCK) begin
                        comma_cnt_d = comma_cnt + CCW'(1);
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    byte_strobe_d = 1'b1;
                    out_data_d    = sr_next;
                    out_valid_d   = !comma_hit;
                end
            end
            default: begin
                bit_cnt_d = '0;
            end
        endcase
    end

endmodule
